timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter DEFAULT_PRESCALE, 25000000, prescaler reset value; one tick per (PRESCALE+1) clk cycles.
REQ-002 Parameter DEFAULT_RELOAD, 0, main-counter reload value after reset.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 bus_addr  in  2  register select: 0 CTRL, 1 PRESCALE, 2 RELOAD, 3 STATUS.
REQ-006 bus_we  in  1  write strobe; one write per asserted cycle.
REQ-007 bus_re  in  1  read strobe.
REQ-008 bus_wdata  in  32  write data.
REQ-009 bus_rdata  out  32  read data, registered.
REQ-010 irq  out  1  level interrupt = pending AND CTRL.IE.
REQ-011 irq_ack  in  1  single-cycle pulse; clears pending.
REQ-012 tick_out  out  1  square wave; toggles on every prescaler tick.

Function
REQ-013 CTRL bits: [0] EN, [1] PERIODIC, [2] IE; other bits read 0.
REQ-014 STATUS read: [31:1] = current count[30:0], [0] = pending; STATUS write with bit0=1 clears pending; other write bits ignored.
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN when EN is written 1; RUN->IDLE when EN is written 0; RUN->DONE on one-shot expiry; DONE->RUN when EN is rewritten 1; DONE->IDLE when EN is written 0.
REQ-016 On entry to RUN: prescale counter = 0; main count = RELOAD.
REQ-017 In RUN, prescale counter increments each cycle; when it equals PRESCALE: one-cycle internal tick, counter returns to 0, tick_out toggles.
REQ-018 On tick with count != 0: count decrements by 1.
REQ-019 On tick with count == 0: expiry; pending set; PERIODIC=1 reloads count from RELOAD and stays in RUN; PERIODIC=0 enters DONE and hardware clears EN.
REQ-020 PRESCALE=0: tick every cycle. RELOAD=0: expiry on every tick.
REQ-021 Period between expiries = (PRESCALE+1)*(RELOAD+1) cycles.
REQ-022 Writes to PRESCALE or RELOAD while in RUN do not disturb current counters; new values apply at next wrap or reload.
REQ-023 Expiry coinciding with a pending clear (STATUS write or irq_ack): pending remains 1.
REQ-024 In IDLE and DONE: counters hold; tick_out holds; pending retained.
REQ-025 bus_rdata is valid the cycle after bus_re; it holds its value when bus_re=0.
REQ-026 Simultaneous bus_we and bus_re to the same register: read returns the pre-write value.
REQ-027 irq deasserts in the cycle after a pending clear unless REQ-023 applies.

Reset
REQ-028 rst_n low: FSM IDLE; CTRL=0; PRESCALE=DEFAULT_PRESCALE; RELOAD=DEFAULT_RELOAD; counters=0; pending=0; tick_out=0; irq=0; bus_rdata=0.
REQ-029 Reset asserted mid-RUN aborts the count immediately, with no expiry and no irq.

Structure
REQ-030 The shared package holds register address constants, CTRL bit indices, and the FSM state encoding.
REQ-031 The prescaler is sub-module timer_prescaler, with inputs clk, rst_n, en, restart, limit[31:0] and outputs tick and tick_out; the FSM, register file, and main counter stay in timer_ctrl.

Verification
REQ-032 Test 1: PRESCALE=3, RELOAD=2, CTRL=3'b111. Required: pending set and irq high every 12 cycles; tick_out toggles every 4 cycles.
REQ-033 Test 2: one-shot, PRESCALE=0, RELOAD=5. Required: expiry 6 cycles after EN; then DONE; CTRL reads 3'b100 with IE=1; count holds 0.
REQ-034 Test 3: irq_ack pulsed in the same cycle as expiry. Required: pending stays 1; a later irq_ack clears it and irq drops the next cycle.
REQ-035 Test 4: write RELOAD=9 mid-run with RELOAD=2 periodic. Required: current period unchanged; next period is (PRESCALE+1)*10 cycles.
REQ-036 Test 5: rst_n pulsed low mid-RUN with count=1. Required: all outputs take reset values asynchronously; no irq follows.
REQ-037 Test 6: read STATUS after RELOAD=7 and EN=1, PRESCALE=DEFAULT. Required: bus_rdata = 32'h0000000E one cycle after bus_re.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer block.
// Register map, CTRL bit positions and FSM encoding.
package timer_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_RELOAD   = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: one tick per (limit+1) enabled cycles.
// The limit is latched on restart and at each wrap.
module timer_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        restart,
  input  logic [31:0] limit,
  output logic        tick,
  output logic        tick_out
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lim_q, lim_d;
  logic        tout_q, tout_d;

  assign tick     = en && (cnt_q == lim_q);
  assign tick_out = tout_q;

  // Next-state: restart clears, wrap reloads limit and toggles output.
  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    tout_d = tout_q;
    if (restart) begin
      cnt_d = '0;
      lim_d = limit;
    end else if (tick) begin
      cnt_d  = '0;
      lim_d  = limit;
      tout_d = ~tout_q;
    end else if (en) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lim_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      tout_q <= tout_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: register file, FSM and main down-counter.
// Prescaler lives in timer_prescaler.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PRESCALE = 32'd25000000,
  parameter logic [31:0] DEFAULT_RELOAD   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq,
  input  logic        irq_ack,
  output logic        tick_out
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_ctrl, wr_presc, wr_reload, wr_status;
  logic run, tick, restart, expire, clr;

  assign wr_ctrl   = bus_we && (bus_addr == ADDR_CTRL);
  assign wr_presc  = bus_we && (bus_addr == ADDR_PRESCALE);
  assign wr_reload = bus_we && (bus_addr == ADDR_RELOAD);
  assign wr_status = bus_we && (bus_addr == ADDR_STATUS);

  assign run     = (state_q == ST_RUN);
  assign restart = wr_ctrl && bus_wdata[CTRL_EN] && !run;
  assign expire  = tick && (count_q == 32'd0);
  assign clr     = irq_ack || (wr_status && bus_wdata[0]);

  assign irq       = pend_q && ctrl_q[CTRL_IE];
  assign bus_rdata = rdata_q;

  timer_prescaler u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (run),
    .restart  (restart),
    .limit    (presc_q),
    .tick     (tick),
    .tick_out (tick_out)
  );

  // FSM and CTRL: software writes win over a same-cycle one-shot expiry.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    if (run && expire && !ctrl_q[CTRL_PERIODIC]) begin
      state_d         = ST_DONE;
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr_ctrl) begin
      ctrl_d  = bus_wdata[2:0];
      state_d = bus_wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
    end
  end

  // Main counter, pending flag and config registers.
  always_comb begin
    presc_d  = wr_presc ? bus_wdata : presc_q;
    reload_d = wr_reload ? bus_wdata : reload_q;
    count_d  = count_q;
    if (restart) begin
      count_d = reload_q;
    end else if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q[CTRL_PERIODIC]) begin
        count_d = reload_q;
      end
    end
    pend_d = pend_q;
    if (expire) begin
      pend_d = 1'b1;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  // Registered read port; returns pre-write values.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_re) begin
      case (bus_addr)
        ADDR_CTRL:     rdata_d = {29'd0, ctrl_q};
        ADDR_PRESCALE: rdata_d = presc_q;
        ADDR_RELOAD:   rdata_d = reload_q;
        default:       rdata_d = {count_q[30:0], pend_q};
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      presc_q  <= DEFAULT_PRESCALE;
      reload_q <= DEFAULT_RELOAD;
      count_q  <= '0;
      pend_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
